lfsr_checker: RTL

Receive-side companion to the 32-bit Fibonacci LFSR generator: consumes the serial bit stream the generator emits (its bit 0, one bit per enabled step), self-synchronises to the sequence and then checks every further bit against a local prediction. It sits at the far end of any link or loopback carrying the pseudo-random stream. It reports lock status, per-bit mismatches and a saturating error total for on-board self-test.

---
 rtl/lfsr_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Purpose: self-synchronising receive checker for the 32-bit Fibonacci LFSR stream.
// Latency: bit_err/err_count one cycle after the checked enable; locked one cycle after the 32nd fill bit.
// Backpressure: none; consumes one bit per enable cycle, state holds while enable is low.
module lfsr_checker #(
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_bit,
  input  logic             clr_err,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      shadow
);

  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] LOSS_LIM = WE_W'(LOSS_THRESH);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [5:0]      fill, fill_nxt;
  logic [31:0]     shadow_nxt;
  logic [WC_W-1:0] win_cnt, win_cnt_nxt;
  logic [WE_W-1:0] win_err, win_err_nxt, win_err_inc;
  logic            pred;
  logic            mism;

  // Predict the next bit, detect mismatches and work out next state for FSM, shadow and window.
  always_comb begin
    pred        = shadow[31] ^ shadow[30] ^ shadow[29] ^ shadow[27] ^ shadow[25] ^ shadow[0];
    mism        = (state == LOCKED) && enable && (in_bit != pred);
    win_err_inc = win_err + WE_W'(1);
    state_nxt   = state;
    fill_nxt    = fill;
    shadow_nxt  = shadow;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    if (enable) begin
      case (state)
        HUNT: begin
          // Load raw received bits until 32 are in, then lock unless that is the all-zero lockup.
          shadow_nxt = {in_bit, shadow[31:1]};
          if (fill == 6'd31) begin
            fill_nxt = 6'd0;
            if (shadow_nxt != 32'd0) begin
              state_nxt   = LOCKED;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end
          end else begin
            fill_nxt = fill + 6'd1;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so an isolated bad bit does not corrupt the local state.
          shadow_nxt = {pred, shadow[31:1]};
          if (mism && (win_err_inc == LOSS_LIM)) begin
            state_nxt   = HUNT;
            fill_nxt    = 6'd0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + WC_W'(1);
            win_err_nxt = mism ? win_err_inc : win_err;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_nxt;
  end

  // Datapath registers: fill, shadow, window counters, error pulse and saturating error total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill      <= 6'd0;
      shadow    <= 32'd0;
      win_cnt   <= '0;
      win_err   <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
    end else begin
      fill    <= fill_nxt;
      shadow  <= shadow_nxt;
      win_cnt <= win_cnt_nxt;
      win_err <= win_err_nxt;
      bit_err <= mism;
      if (clr_err)                         err_count <= '0;
      else if (mism && (err_count != '1))  err_count <= err_count + ERR_W'(1);
    end
  end

  assign locked = (state == LOCKED);

endmodule
